if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline. Sits directly upstream of the decode stage.
- Owns the PC register and drives a request/ready instruction-memory port that tolerates variable latency (BRAM or UART-loaded memory).
- Applies branch/jump redirects coming back from decode with MIPS delay-slot semantics.
- Its registered outputs form the IF/ID pipeline register consumed by decode.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0000, bubble instruction presented to decode when no valid fetch is available.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset rst, synchronous, active-high
- stall  in  1  pipeline hold from hazard logic (decode stall_req OR later stages); 1 = decode must not advance
- branch_flag  in  1  decode resolved a taken branch/jump this cycle
- branch_addr  in  32  redirect target from decode
- imem_req  out  1  fetch request, combinational from state
- imem_addr  out  32  fetch address, equals current pc
- imem_rdata  in  32  instruction word; valid only while imem_ready=1
- imem_ready  in  1  memory response; may assert in the same cycle as imem_req (zero-wait)
- if_pc  out  32  registered PC of the instruction on if_inst
- if_inst  out  32  registered instruction to decode
- if_valid  out  1  registered; 1 = if_inst is a real fetched instruction
- misalign_err  out  1  one-cycle pulse when a redirect target has a nonzero addr[1:0]

Behaviour:
- Reset (rst=1 at edge):
  - pc=RESET_PC, state=S_FETCH.
  - if_pc=RESET_PC, if_inst=NOP_INST, if_valid=0, misalign_err=0.
  - Pending-redirect flag and hold buffer cleared.
  - imem_req=0 during any cycle where rst=1.
  - Reset mid-fetch abandons the outstanding request; a late imem_ready is ignored while rst=1.
- States:
  - S_FETCH: imem_req=1, imem_addr=pc.
  - S_HOLD: imem_req=0, instruction held in internal buffer.
- S_FETCH, imem_ready=1, stall=0:
  - if_inst<=imem_rdata, if_pc<=pc, if_valid<=1.
  - pc<=next target (see Redirect).
  - Remain in S_FETCH.
- S_FETCH, imem_ready=1, stall=1:
  - Buffer rdata and pc; go S_HOLD.
  - IF/ID outputs unchanged.
- S_FETCH, imem_ready=0, stall=0: if_inst<=NOP_INST, if_valid<=0 (bubble); pc unchanged.
- S_FETCH, imem_ready=0, stall=1: all outputs unchanged.
- S_HOLD, stall=1: stay in S_HOLD.
- S_HOLD, stall=0: IF/ID outputs <= buffer, if_valid<=1, pc<=next target, go S_FETCH.
- Throughput: with zero-wait memory, one instruction per cycle. Fetch-to-decode latency is 1 edge.
- Redirect:
  - branch_flag is honoured only at an edge with stall=0.
  - The instruction fetched concurrently with the branch being in decode is the delay slot and is always delivered to decode.
  - If the delay slot is delivered at that same edge, pc<=target. Otherwise, latch pending_redirect=1 and target; when the delay slot is later delivered, pc<=target and pending_redirect is cleared.
  - Without a redirect, next target = pc+4 (32-bit wrap: 32'hFFFF_FFFC -> 32'h0000_0000).
  - Target alignment: target={branch_addr[31:2],2'b00}. misalign_err<=1 for one cycle if branch_addr[1:0]!=0.
  - branch_flag while pending_redirect=1 is ignored; decode cannot legally produce it.
  - branch_flag with stall=1 is ignored; decode re-asserts it next cycle.

Optional Feature:
- Macro IF_SQUASH_DELAY_SLOT_EN.
- Defined:
  - On a honoured redirect, the delay-slot instruction is replaced by NOP_INST with if_valid=0, whether it is delivered at the same edge, still in flight, or buffered in S_HOLD.
  - No memory cycle is wasted beyond the one already issued.
  - Link address produced by decode is unaffected.
- Undefined: delay slot executes (standard MIPS behaviour as described above).

Test Plan:
1. rst=1 for 2 cycles, then 0; zero-wait memory returning imem_addr as data -> if_pc sequence 0,4,8,C on consecutive edges, if_valid=1 from first edge after reset, if_inst=if_pc.
2. imem_ready held 0 for 3 cycles at pc=8, stall=0 -> three bubbles (if_inst=NOP_INST, if_valid=0), then if_pc=8 delivered; pc stays 8 throughout the wait.
3. stall=1 for 2 cycles while rdata at pc=0xC returns -> outputs frozen at previous instruction, imem_req=0 in S_HOLD; on stall release if_pc=0xC, next fetch addr 0x10.
4. Decode holds branch at 0x10 with branch_flag=1, branch_addr=0x40, stall=0 -> if_pc 0x14 (delay slot, if_valid=1) then 0x40; with IF_SQUASH_DELAY_SLOT_EN, 0x14 slot shows NOP_INST with if_valid=0, then 0x40.
5. Same as 4 but delay-slot fetch takes 2 extra cycles -> bubbles, then 0x14 delivered, then imem_addr=0x40; branch_addr=0x42 variant -> misalign_err pulses once, fetch from 0x40.
6. Assert rst while S_HOLD with pending_redirect set -> next cycle pc=RESET_PC, if_valid=0, buffer and pending flag cleared, late imem_ready ignored.

Source files
------------

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, variable-latency imem request/ready port, IF/ID register.
// Optional build macro IF_SQUASH_DELAY_SLOT_EN replaces the branch delay slot with a bubble.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_flag,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid,
  output logic        misalign_err
);

  typedef enum logic {S_FETCH, S_HOLD} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] hold_inst;
  logic [31:0] hold_pc;
  logic [31:0] pend_tgt;
  logic        pend;

  logic        honour;
  logic        deliver;
  logic        squash;
  logic [31:0] tgt;
  logic [31:0] next_pc;
  logic [31:0] dlv_inst;
  logic [31:0] dlv_pc;

  assign imem_req  = (state == S_FETCH) && !rst;
  assign imem_addr = pc;

  // A redirect is taken only on an advancing edge and never on top of a pending one.
  assign honour  = branch_flag && !stall && !pend;
  assign tgt     = {branch_addr[31:2], 2'b00};
  assign deliver = !stall && ((state == S_HOLD) || imem_ready);
  assign dlv_inst = (state == S_HOLD) ? hold_inst : imem_rdata;
  assign dlv_pc   = (state == S_HOLD) ? hold_pc   : pc;
  assign next_pc  = honour ? tgt : (pend ? pend_tgt : pc + 32'd4);

`ifdef IF_SQUASH_DELAY_SLOT_EN
  // Whatever is delivered while a redirect is live is the delay slot.
  assign squash = honour || pend;
`else
  assign squash = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_FETCH;
      pc           <= RESET_PC;
      hold_inst    <= NOP_INST;
      hold_pc      <= RESET_PC;
      pend         <= 1'b0;
      pend_tgt     <= RESET_PC;
      if_pc        <= RESET_PC;
      if_inst      <= NOP_INST;
      if_valid     <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= honour && (branch_addr[1:0] != 2'b00);
      if (deliver) begin
        if_pc    <= dlv_pc;
        if_inst  <= squash ? NOP_INST : dlv_inst;
        if_valid <= !squash;
        pc       <= next_pc;
        pend     <= 1'b0;
        state    <= S_FETCH;
      end else if (state == S_FETCH && imem_ready) begin
        hold_inst <= imem_rdata;
        hold_pc   <= pc;
        state     <= S_HOLD;
      end else if (state == S_FETCH && !stall) begin
        if_inst  <= NOP_INST;
        if_valid <= 1'b0;
        if (honour) begin
          pend     <= 1'b1;
          pend_tgt <= tgt;
        end
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: scoreboard of expected IF/ID values checked one edge after driving.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;
`ifdef IF_SQUASH_DELAY_SLOT_EN
  localparam bit SQ = 1'b1;
`else
  localparam bit SQ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch_flag = 1'b0;
  logic [31:0] branch_addr = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready = 1'b0;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;
  logic        misalign_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
    logic        mis;
    logic        chk_pc;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  // Memory returns its address as data; garbage when not ready.
  assign imem_rdata = imem_ready ? imem_addr : 32'hDEAD_BEEF;

  if_stage #(.RESET_PC(32'h0), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_flag(branch_flag), .branch_addr(branch_addr),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid),
    .misalign_err(misalign_err)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic bf, input logic [31:0] ba,
                      input logic [31:0] epc, input logic [31:0] einst, input logic ev,
                      input logic em, input logic cpc);
    exp_t e;
    exp_t got;
    e.pc = epc; e.inst = einst; e.valid = ev; e.mis = em; e.chk_pc = cpc;
    sb.push_back(e);
    imem_ready = r; stall = s; branch_flag = bf; branch_addr = ba;
    @(posedge clk);
    #1;
    got = sb.pop_front();
    if (got.chk_pc) chk("if_pc", if_pc, got.pc);
    chk("if_inst", if_inst, got.inst);
    chk("if_valid", {31'b0, if_valid}, {31'b0, got.valid});
    chk("misalign_err", {31'b0, misalign_err}, {31'b0, got.mis});
  endtask

  // Normal delivery and delay-slot delivery (bubble when squashing).
  task automatic go(input logic [31:0] a);
    step(1, 0, 0, 0, a, a, 1, 0, 1);
  endtask

  task automatic slot(input logic bf, input logic [31:0] ba, input logic [31:0] a, input logic em);
    step(1, 0, bf, ba, a, SQ ? NOP : a, !SQ, em, 1);
  endtask

  initial begin
    // Reset, with a late ready that must be ignored.
    step(1, 0, 0, 0, 32'h0, NOP, 0, 0, 1);
    chk("req_in_rst", {31'b0, imem_req}, 32'h0);
    step(1, 0, 0, 0, 32'h0, NOP, 0, 0, 1);
    rst = 1'b0;
    #1;
    chk("req_after_rst", {31'b0, imem_req}, 32'h1);
    chk("addr_after_rst", imem_addr, 32'h0);

    // Zero-wait streaming.
    go(32'h0);
    go(32'h4);
    chk("addr_wait", imem_addr, 32'h8);

    // Three wait cycles at pc=8.
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 32'h4, NOP, 0, 0, 1);
      chk("addr_hold8", imem_addr, 32'h8);
    end
    go(32'h8);

    // Stall with response arriving: hold buffer.
    step(1, 1, 0, 0, 32'h8, 32'h8, 1, 0, 1);
    chk("req_in_hold", {31'b0, imem_req}, 32'h0);
    step(1, 1, 0, 0, 32'h8, 32'h8, 1, 0, 1);
    chk("req_in_hold2", {31'b0, imem_req}, 32'h0);
    go(32'hC);
    chk("addr_after_hold", imem_addr, 32'h10);

    // Branch at 0x10, delay slot delivered same edge.
    go(32'h10);
    slot(1, 32'h40, 32'h14, 0);
    chk("addr_redirect", imem_addr, 32'h40);
    go(32'h40);

    // Branch with delay slot two cycles late.
    step(0, 0, 1, 32'h80, 32'h40, NOP, 0, 0, 1);
    step(0, 0, 0, 0, 32'h40, NOP, 0, 0, 1);
    chk("addr_pending", imem_addr, 32'h44);
    slot(0, 0, 32'h44, 0);
    chk("addr_pend_redirect", imem_addr, 32'h80);
    go(32'h80);

    // Misaligned target.
    slot(1, 32'hC2, 32'h84, 1);
    chk("addr_misalign", imem_addr, 32'hC0);
    go(32'hC0);

    // Pending redirect plus hold buffer, then reset.
    step(0, 0, 1, 32'h100, 32'hC0, NOP, 0, 0, 1);
    step(1, 1, 0, 0, 32'hC0, NOP, 0, 0, 1);
    rst = 1'b1;
    step(1, 0, 0, 0, 32'h0, NOP, 0, 0, 1);
    chk("req_rst2", {31'b0, imem_req}, 32'h0);
    chk("addr_rst2", imem_addr, 32'h0);
    rst = 1'b0;
    go(32'h0);
    chk("addr_no_pend", imem_addr, 32'h4);

    // PC wrap.
    slot(1, 32'hFFFF_FFFC, 32'h4, 0);
    go(32'hFFFF_FFFC);
    chk("addr_wrap", imem_addr, 32'h0);
    go(32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
